roach_dram_read: RTL and testbench

- Read-side counterpart of the ROACH2 DRAM write packer.
- Issues a programmed run of 288-bit read commands at consecutive DRAM addresses and buffers the returned beats in an internal FIFO.
- Unpacks each beat into CYCLES words of DOUT_WIDTH bits, LSB word first, on a valid/ready stream.
- Sits between the DRAM yellow-block interface and downstream readout logic such as a snapshot or 10GbE packetiser.

---
 rtl/roach_dram_read.sv | 202 ++++++++++++++++++++
 tb/tb_roach_dram_read.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roach_dram_read.sv
// roach_dram_read
//   Issues a programmed run of 288-bit DRAM read commands at consecutive
//   addresses, buffers the returned beats in a small FIFO and unpacks each
//   beat into CYCLES words of DOUT_WIDTH bits (LSB word first) on a
//   valid/ready stream.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start/start_addr/n_reads  run launch (ignored while busy)
//   busy, done, tag_error     run status; tag_error is sticky
//   dram_*/wr_be/rwn/cmd_*    DRAM command interface (read-only use)
//   rd_data/rd_tag/rd_valid   DRAM read return, in order
//   dout/dout_valid/dout_ready/dout_last  unpacked word stream
module roach_dram_read #(
    parameter int DOUT_WIDTH = 32,
    parameter int DRAM_ADDR  = 25,
    parameter int FIFO_DEPTH = 8,
    parameter int CYCLES     = 288 / DOUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DRAM_ADDR-1:0]  start_addr,
    input  logic [DRAM_ADDR-1:0]  n_reads,
    output logic                  busy,
    output logic                  done,
    output logic                  tag_error,
    output logic                  dram_rst,
    output logic [DRAM_ADDR-1:0]  dram_addr,
    output logic [287:0]          dram_data,
    output logic [35:0]           wr_be,
    output logic                  rwn,
    output logic [31:0]           cmd_tag,
    output logic                  cmd_valid,
    input  logic                  cmd_ack,
    input  logic [287:0]          rd_data,
    input  logic [31:0]           rd_tag,
    input  logic                  rd_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [WW-1:0]        LAST_W  = WW'(CYCLES - 1);
    localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [DRAM_ADDR-1:0] ONE_A   = DRAM_ADDR'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [DRAM_ADDR-1:0] dram_addr_q, dram_addr_d;
    logic [DRAM_ADDR-1:0] issued_q, issued_d;     // accepted commands == next cmd_tag
    logic [DRAM_ADDR-1:0] n_reads_q, n_reads_d;
    logic [DRAM_ADDR-1:0] ret_idx_q, ret_idx_d;   // expected tag of next return
    logic [DRAM_ADDR-1:0] beats_q, beats_d;       // beats fully consumed
    logic [CW-1:0]        credits_q, credits_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WW-1:0]        widx_q, widx_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 tag_error_q, tag_error_d;
    logic                 done_q, done_d;
    logic [287:0]         mem_q [FIFO_DEPTH];
    logic [287:0]         head;

    logic launch, accept, rd_take, push, beat_end, last_fire;

    assign dram_rst  = 1'b0;
    assign dram_data = '0;
    assign wr_be     = '0;
    assign rwn       = 1'b1;
    assign dram_addr = dram_addr_q;
    assign cmd_tag   = 32'(issued_q);
    assign cmd_valid = cmd_valid_q;
    assign tag_error = tag_error_q;
    assign done      = done_q;
    assign head      = mem_q[rd_ptr_q];

    assign launch    = (state_q == IDLE) && start && (n_reads != '0);
    assign accept    = cmd_valid_q && cmd_ack;
    // Returns arriving while idle are stale (e.g. in flight across a reset).
    assign rd_take   = rd_valid && (state_q != IDLE);
    assign push      = rd_take && (count_q != DEPTH_C);
    assign beat_end  = dout_valid && dout_ready && (widx_q == LAST_W);
    assign last_fire = dout_last && dout_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = ISSUE;
            ISSUE: begin
                if (last_fire) state_d = IDLE;
                else if (accept && (issued_q + ONE_A == n_reads_q)) state_d = DRAIN;
            end
            DRAIN:   if (last_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the stream is driven straight from the FIFO head so a
    // beat written on one edge is visible the very next cycle.
    always_comb begin
        busy       = (state_q != IDLE);
        dout_valid = busy && (count_q != '0);
        dout_last  = dout_valid && (widx_q == LAST_W) && (beats_q == n_reads_q - ONE_A);
        dout       = dout_valid ? head[int'(widx_q) * DOUT_WIDTH +: DOUT_WIDTH] : '0;
    end

    // Datapath next values
    always_comb begin
        dram_addr_d = dram_addr_q;
        issued_d    = issued_q;
        n_reads_d   = n_reads_q;
        ret_idx_d   = ret_idx_q;
        beats_d     = beats_q;
        credits_d   = credits_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        widx_d      = widx_q;
        tag_error_d = tag_error_q;
        done_d      = last_fire || ((state_q == IDLE) && start && (n_reads == '0));
        if (launch) begin
            dram_addr_d = start_addr;
            issued_d    = '0;
            n_reads_d   = n_reads;
            ret_idx_d   = '0;
            beats_d     = '0;
            credits_d   = '0;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            widx_d      = '0;
            tag_error_d = 1'b0;
        end else begin
            if (accept) begin
                dram_addr_d = dram_addr_q + ONE_A;
                issued_d    = issued_q + ONE_A;
            end
            // A credit is held from command accept until its beat is consumed.
            credits_d = credits_q + CW'(accept) - CW'(beat_end);
            count_d   = count_q + CW'(push) - CW'(beat_end);
            if (rd_take) begin
                ret_idx_d = ret_idx_q + ONE_A;
                if (!push || (rd_tag != 32'(ret_idx_q))) tag_error_d = 1'b1;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (dout_valid && dout_ready) widx_d = (widx_q == LAST_W) ? '0 : widx_q + WW'(1);
            if (beat_end) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                beats_d  = beats_q + ONE_A;
            end
        end
        cmd_valid_d = (state_d == ISSUE) && (issued_d < n_reads_d) && (credits_d < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dram_addr_q <= '0;
            issued_q    <= '0;
            n_reads_q   <= '0;
            ret_idx_q   <= '0;
            beats_q     <= '0;
            credits_q   <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            widx_q      <= '0;
            cmd_valid_q <= 1'b0;
            tag_error_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dram_addr_q <= dram_addr_d;
            issued_q    <= issued_d;
            n_reads_q   <= n_reads_d;
            ret_idx_q   <= ret_idx_d;
            beats_q     <= beats_d;
            credits_q   <= credits_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            widx_q      <= widx_d;
            cmd_valid_q <= cmd_valid_d;
            tag_error_q <= tag_error_d;
            done_q      <= done_d;
        end
    end

    // Beat storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rd_data;
    end
endmodule

// File: tb/tb_roach_dram_read.sv
module tb_roach_dram_read;
    localparam int W = 32, AW = 25, DEPTH = 8, CYC = 9;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [AW-1:0] start_addr = '0, n_reads = '0;
    logic busy, done, tag_error, dram_rst, rwn, cmd_valid, dout_valid, dout_last;
    logic [AW-1:0] dram_addr;
    logic [287:0] dram_data;
    logic [35:0] wr_be;
    logic [31:0] cmd_tag;
    logic [W-1:0] dout;
    logic cmd_ack = 1'b0, rd_valid = 1'b0, dout_ready = 1'b0;
    logic [287:0] rd_data = '0;
    logic [31:0] rd_tag = '0;

    roach_dram_read dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .n_reads(n_reads),
        .busy(busy), .done(done), .tag_error(tag_error), .dram_rst(dram_rst),
        .dram_addr(dram_addr), .dram_data(dram_data), .wr_be(wr_be), .rwn(rwn),
        .cmd_tag(cmd_tag), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack), .rd_data(rd_data),
        .rd_tag(rd_tag), .rd_valid(rd_valid), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] tag; logic [287:0] data; } ret_t;

    int vectors = 0, miscompares = 0;
    // Knobs for the DRAM / sink model
    int lat = 3, ack_pct = 100, slow_ack = 0, ready_mode = 0, corrupt_idx = -1, data_inc = 0;
    // Observations
    int cyc = 0, wcnt = 0, start_cyc = 0;
    int done_cnt, done_cyc, last_word_cyc, hold_err, credit_err, cv_seen, busy_seen;
    int first_cv_cyc, first_rd_cyc, first_dv_cyc;
    logic [AW-1:0] acc_addr[$];
    logic [31:0] acc_tag[$];
    logic [31:0] exp_w[$], got_w[$];
    int last_pos[$];
    ret_t ret_q[$];
    logic prev_cv = 0, prev_acc = 0, acc;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0] prev_tag = '0;
    logic [287:0] resp_d;

    // DRAM and sink model: acts at every falling edge, decides inputs for the
    // coming rising edge and records the handshakes that edge will complete.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (cmd_valid) wcnt++;
        if (slow_ack != 0) cmd_ack = (wcnt > 5);
        else cmd_ack = (int'($urandom_range(99)) < ack_pct);
        if (cmd_valid && prev_cv && !prev_acc && (dram_addr !== prev_addr || cmd_tag !== prev_tag))
            hold_err++;
        if (cmd_valid && (acc_tag.size() - got_w.size() / CYC) >= DEPTH) credit_err++;
        if (cmd_valid) begin
            cv_seen = 1;
            if (first_cv_cyc < 0) first_cv_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        acc = cmd_valid && cmd_ack;
        if (acc) begin
            for (int k = 0; k < CYC; k++) begin
                resp_d[k*W +: W] = (data_inc != 0) ? 32'(k + 1) : $urandom();
                exp_w.push_back(resp_d[k*W +: W]);
            end
            acc_addr.push_back(dram_addr);
            acc_tag.push_back(cmd_tag);
            ret_q.push_back('{cyc + lat,
                              (acc_tag.size() - 1 == corrupt_idx) ? 32'd5 : 32'(acc_tag.size() - 1),
                              resp_d});
            wcnt = 0;
        end
        prev_cv = cmd_valid; prev_acc = acc; prev_addr = dram_addr; prev_tag = cmd_tag;
        case (ready_mode)
            0: dout_ready = 1'b1;
            1: dout_ready = ~dout_ready;
            2: dout_ready = (int'($urandom_range(99)) < 60);
            default: dout_ready = 1'b0;
        endcase
        if (dout_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
        if (dout_valid && dout_ready) begin
            got_w.push_back(dout);
            if (dout_last) begin
                last_pos.push_back(got_w.size() - 1);
                last_word_cyc = cyc;
            end
        end
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            rd_valid = 1'b1; rd_data = ret_q[0].data; rd_tag = ret_q[0].tag;
            void'(ret_q.pop_front());
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end else begin
            rd_valid = 1'b0; rd_data = '0; rd_tag = '0;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    function automatic int stream_bad();
        int b = (exp_w.size() != got_w.size()) ? 1 : 0;
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            if (exp_w[i] !== got_w[i]) b++;
        return b;
    endfunction

    function automatic int addr_bad(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] e;
        int b = (acc_addr.size() != n) ? 1 : 0;
        for (int i = 0; i < acc_addr.size(); i++) begin
            e = a + AW'(i);
            if (acc_addr[i] !== e || acc_tag[i] !== 32'(i)) b++;
        end
        return b;
    endfunction

    function automatic int last_at();
        return (last_pos.size() == 1) ? last_pos[0] : -1;
    endfunction

    task automatic step();
        @(negedge clk); #2;
    endtask

    task automatic clear_mon();
        acc_addr.delete(); acc_tag.delete(); exp_w.delete(); got_w.delete(); last_pos.delete();
        done_cnt = 0; done_cyc = -1; last_word_cyc = -1; hold_err = 0; credit_err = 0;
        cv_seen = 0; busy_seen = 0; first_cv_cyc = -1; first_rd_cyc = -1; first_dv_cyc = -1;
        wcnt = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input logic [AW-1:0] n);
        step(); start = 1'b1; start_addr = a; n_reads = n; start_cyc = cyc;
        step(); start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            if (done_cnt > 0) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; clear_mon();
        repeat (3) step();
        vectors++;
        if ({busy, done, tag_error, cmd_valid, dout_valid, dout_last} !== 6'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b want 000000", {busy, done, tag_error, cmd_valid, dout_valid, dout_last});
        end
        vectors++;
        if (dram_addr !== '0 || cmd_tag !== '0 || dout !== '0) begin
            miscompares++; $display("FAIL reset_regs: addr %h tag %h dout %h want 0", dram_addr, cmd_tag, dout);
        end
        vectors++;
        if ({rwn, dram_rst} !== 2'b10 || wr_be !== '0 || dram_data !== '0) begin
            miscompares++; $display("FAIL reset_consts: rwn %b dram_rst %b be %h", rwn, dram_rst, wr_be);
        end
        rst = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_single();
        bit ok;
        lat = 3; ack_pct = 100; slow_ack = 0; ready_mode = 0; corrupt_idx = -1; data_inc = 1;
        clear_mon();
        pulse_start(25'h10, 25'd1);
        vectors++;
        if (busy !== 1'b1 || first_cv_cyc != start_cyc + 1) begin
            miscompares++; $display("FAIL single_issue: busy %b cv_cyc %0d want 1 and %0d", busy, first_cv_cyc, start_cyc + 1);
        end
        wait_done(500, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_timeout: done %0d want 1", done_cnt); end
        vectors++;
        if (addr_bad(25'h10, 1) != 0) begin
            miscompares++; $display("FAIL single_cmd: %0d accepts, bad %0d want 1 at 0x10", acc_addr.size(), addr_bad(25'h10, 1));
        end
        for (int k = 0; k < CYC; k++) begin
            vectors++;
            if (k >= got_w.size() || got_w[k] !== 32'(k + 1)) begin
                miscompares++; $display("FAIL single_word%0d: got %h want %0d", k, (k < got_w.size()) ? got_w[k] : 32'hx, k + 1);
            end
        end
        vectors++;
        if (got_w.size() != CYC || last_at() != CYC - 1) begin
            miscompares++; $display("FAIL single_last: words %0d last %0d want 9 and 8", got_w.size(), last_at());
        end
        vectors++;
        if (done_cyc != last_word_cyc + 1 || first_dv_cyc != first_rd_cyc + 1) begin
            miscompares++; $display("FAIL single_timing: done %0d last %0d dv %0d rd %0d", done_cyc, last_word_cyc, first_dv_cyc, first_rd_cyc);
        end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || tag_error !== 1'b0 || done_cnt != 1) begin
            miscompares++; $display("FAIL single_end: done %b busy %b terr %b pulses %0d", done, busy, tag_error, done_cnt);
        end
        data_inc = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [AW-1:0] a;
        a = AW'($urandom());
        lat = $urandom_range(2, 6); ack_pct = 100; ready_mode = 1; corrupt_idx = -1;
        clear_mon();
        pulse_start(a, 25'd4);
        wait_done(1000, ok);
        vectors++;
        if (!ok || got_w.size() != 36 || stream_bad() != 0 || last_at() != 35) begin
            miscompares++; $display("FAIL bp_stream: ok %0d words %0d bad %0d last %0d want 36/0/35", ok, got_w.size(), stream_bad(), last_at());
        end
        vectors++;
        if (addr_bad(a, 4) != 0) begin miscompares++; $display("FAIL bp_addr: bad %0d want 0", addr_bad(a, 4)); end
        // Hold the sink off so the run fills every credit.
        a = AW'($urandom());
        lat = 2; ready_mode = 3;
        clear_mon();
        pulse_start(a, 25'd12);
        repeat (40) step();
        vectors++;
        if (acc_tag.size() != DEPTH) begin
            miscompares++; $display("FAIL bp_credit_stall: accepts %0d want %0d", acc_tag.size(), DEPTH);
        end
        ready_mode = 1;
        wait_done(1000, ok);
        vectors++;
        if (!ok || stream_bad() != 0 || addr_bad(a, 12) != 0 || credit_err != 0) begin
            miscompares++; $display("FAIL bp_full: ok %0d bad %0d addr %0d credit %0d", ok, stream_bad(), addr_bad(a, 12), credit_err);
        end
    endtask

    task automatic test_slow_ack();
        bit ok;
        logic [AW-1:0] a;
        a = AW'($urandom());
        lat = 2; slow_ack = 1; ready_mode = 0; corrupt_idx = -1;
        clear_mon();
        pulse_start(a, 25'd3);
        wait_done(1000, ok);
        slow_ack = 0;
        vectors++;
        if (!ok || addr_bad(a, 3) != 0 || hold_err != 0) begin
            miscompares++; $display("FAIL slow_ack: ok %0d accepts %0d addr %0d hold %0d want 3/0/0", ok, acc_tag.size(), addr_bad(a, 3), hold_err);
        end
        vectors++;
        if (stream_bad() != 0) begin miscompares++; $display("FAIL slow_stream: bad %0d want 0", stream_bad()); end
    endtask

    task automatic test_wrap();
        bit ok;
        lat = 2; ready_mode = 0; corrupt_idx = -1;
        clear_mon();
        pulse_start(25'h1FFFFFF, 25'd2);
        wait_done(500, ok);
        vectors++;
        if (!ok || acc_addr.size() != 2 || acc_addr[0] !== 25'h1FFFFFF || acc_addr[1] !== 25'h0) begin
            miscompares++; $display("FAIL wrap: ok %0d n %0d addrs %h %h want 1ffffff 0000000", ok, acc_addr.size(),
                                    (acc_addr.size() > 0) ? acc_addr[0] : 'x, (acc_addr.size() > 1) ? acc_addr[1] : 'x);
        end
    endtask

    task automatic test_tag_error();
        bit ok;
        lat = 3; ready_mode = 0; corrupt_idx = 1;
        clear_mon();
        pulse_start(AW'($urandom()), 25'd3);
        wait_done(500, ok);
        corrupt_idx = -1;
        repeat (5) step();
        vectors++;
        if (!ok || tag_error !== 1'b1) begin
            miscompares++; $display("FAIL tag_err_set: ok %0d tag_error %b want 1", ok, tag_error);
        end
        vectors++;
        if (stream_bad() != 0) begin miscompares++; $display("FAIL tag_err_data: bad %0d want 0", stream_bad()); end
        clear_mon();
        pulse_start(AW'($urandom()), 25'd1);
        vectors++;
        if (tag_error !== 1'b0) begin miscompares++; $display("FAIL tag_err_clear: got %b want 0", tag_error); end
        wait_done(500, ok);
        vectors++;
        if (!ok || tag_error !== 1'b0) begin miscompares++; $display("FAIL tag_err_clean: ok %0d tag_error %b", ok, tag_error); end
    endtask

    task automatic test_zero();
        clear_mon();
        pulse_start(25'h55, 25'd0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL zero_done: done %b busy %b want 1 0", done, busy);
        end
        repeat (5) step();
        vectors++;
        if (cv_seen != 0 || busy_seen != 0 || done_cnt != 1) begin
            miscompares++; $display("FAIL zero_quiet: cv %0d busy %0d pulses %0d want 0 0 1", cv_seen, busy_seen, done_cnt);
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        logic [AW-1:0] a;
        a = AW'($urandom());
        lat = 4; ready_mode = 2; corrupt_idx = -1;
        clear_mon();
        pulse_start(a, 25'd5);
        repeat (3) step();
        pulse_start(a + 25'h100, 25'd2);
        wait_done(1000, ok);
        repeat (5) step();
        vectors++;
        if (!ok || addr_bad(a, 5) != 0 || done_cnt != 1 || stream_bad() != 0) begin
            miscompares++; $display("FAIL start_busy: ok %0d addr %0d pulses %0d bad %0d want 0 1 0", ok, addr_bad(a, 5), done_cnt, stream_bad());
        end
    endtask

    task automatic test_reset_drain();
        bit ok;
        int g;
        lat = 6; ready_mode = 3; corrupt_idx = -1;
        clear_mon();
        pulse_start(AW'($urandom()), 25'd3);
        for (g = 0; g < 100 && acc_tag.size() < 3; g++) step();
        step();
        vectors++;
        if (acc_tag.size() != 3 || busy !== 1'b1) begin
            miscompares++; $display("FAIL rst_setup: accepts %0d busy %b want 3 1", acc_tag.size(), busy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, tag_error, cmd_valid, dout_valid, dout_last} !== 6'b0 || dram_addr !== '0 || cmd_tag !== '0 || dout !== '0) begin
            miscompares++; $display("FAIL rst_async: flags %b addr %h tag %h dout %h want 0", {busy, done, tag_error, cmd_valid, dout_valid, dout_last}, dram_addr, cmd_tag, dout);
        end
        step();
        rst = 1'b1; ready_mode = 0;
        for (g = 0; g < 100 && ret_q.size() > 0; g++) step();
        repeat (3) step();
        vectors++;
        if (dout_valid !== 1'b0 || tag_error !== 1'b0 || busy !== 1'b0 || ret_q.size() != 0) begin
            miscompares++; $display("FAIL rst_stale: dv %b terr %b busy %b pending %0d want 0", dout_valid, tag_error, busy, ret_q.size());
        end
        lat = 3; ready_mode = 2;
        clear_mon();
        pulse_start(25'h2000, 25'd5);
        wait_done(1000, ok);
        vectors++;
        if (!ok || stream_bad() != 0 || addr_bad(25'h2000, 5) != 0 || last_at() != 5 * CYC - 1 || tag_error !== 1'b0) begin
            miscompares++; $display("FAIL rst_rerun: ok %0d bad %0d addr %0d last %0d terr %b", ok, stream_bad(), addr_bad(25'h2000, 5), last_at(), tag_error);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [AW-1:0] a;
        int n;
        for (int r = 0; r < 5; r++) begin
            a = AW'($urandom()); n = $urandom_range(1, 12);
            lat = $urandom_range(1, 8); ack_pct = $urandom_range(40, 100); ready_mode = 2; corrupt_idx = -1;
            clear_mon();
            pulse_start(a, AW'(n));
            wait_done(3000, ok);
            vectors++;
            if (!ok || stream_bad() != 0 || last_at() != n * CYC - 1) begin
                miscompares++; $display("FAIL rand%0d_stream: ok %0d words %0d bad %0d last %0d want %0d", r, ok, got_w.size(), stream_bad(), last_at(), n * CYC - 1);
            end
            vectors++;
            if (addr_bad(a, n) != 0 || credit_err != 0 || hold_err != 0 || tag_error !== 1'b0) begin
                miscompares++; $display("FAIL rand%0d_cmd: addr %0d credit %0d hold %0d terr %b want 0", r, addr_bad(a, n), credit_err, hold_err, tag_error);
            end
            repeat (3) step();
        end
        ack_pct = 100;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_slow_ack();
        test_wrap();
        test_tag_error();
        test_zero();
        test_start_busy();
        test_reset_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
